// File: rtl/mesi_isc_mon_pkg.sv
// Shared definitions for the mesi_isc coherence monitor.
// Contents: MESI line-state encodings, mbus command encodings, the
// violation-code enum, the ack-tracker state enum, and two small helpers
// that classify a MESI state.
package mesi_isc_mon_pkg;

  localparam logic [3:0] MESI_M = 4'b1001;
  localparam logic [3:0] MESI_E = 4'b0101;
  localparam logic [3:0] MESI_S = 4'b0011;
  localparam logic [3:0] MESI_I = 4'b0000;

  localparam int MBUS_NOP      = 0;
  localparam int MBUS_WR       = 1;
  localparam int MBUS_RD       = 2;
  localparam int MBUS_WR_BROAD = 3;
  localparam int MBUS_RD_BROAD = 4;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_ILLEGAL_ENC = 3'd1,
    ERR_MULTI_OWNER = 3'd2,
    ERR_INIT_NOT_I  = 3'd3,
    ERR_ACK_TIMEOUT = 3'd4,
    ERR_CMD_CHANGED = 3'd5
  } err_code_e;

  typedef enum logic [1:0] {
    TRK_IDLE    = 2'd0,
    TRK_WAIT    = 2'd1,
    TRK_STALLED = 2'd2
  } trk_state_e;

  function automatic logic mesi_legal(input logic [3:0] s);
    return (s == MESI_M) || (s == MESI_E) || (s == MESI_S) || (s == MESI_I);
  endfunction

  function automatic logic mesi_owner(input logic [3:0] s);
    return (s == MESI_M) || (s == MESI_E);
  endfunction

endpackage

// File: rtl/mesi_isc_mon_ack_tracker.sv
// Per-CPU mbus command/ack handshake tracker.
// Handshake: a channel issues a command by driving cmd != NOP; the command
// is complete on the cycle ack is high. cmd must stay stable until then.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            tracker active; when low it is held in IDLE, no flags
//   cmd, ack      the channel's mbus command and ack
//   flag_timeout  combinational: this cycle is the timeout violation cycle
//   flag_changed  combinational: this cycle the pending command changed
//   stalled       high while in STALLED
//   state         current tracker state (debug visibility)
module mesi_isc_mon_ack_tracker
  import mesi_isc_mon_pkg::*;
#(
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [MBUS_CMD_WIDTH-1:0] cmd,
  input  logic                      ack,
  output logic                      flag_timeout,
  output logic                      flag_changed,
  output logic                      stalled,
  output trk_state_e                state
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_NOP = MBUS_CMD_WIDTH'(MBUS_NOP);

  trk_state_e                state_nxt;
  logic [MBUS_CMD_WIDTH-1:0] cmd_lat, cmd_lat_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TRK_IDLE;
      cmd_lat <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      cmd_lat <= cmd_lat_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cmd_lat_nxt  = cmd_lat;
    cnt_nxt      = cnt;
    flag_timeout = 1'b0;
    flag_changed = 1'b0;
    if (!en) begin
      state_nxt = TRK_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        TRK_IDLE: begin
          // A command acked in the same cycle it is issued never waits.
          if (cmd != CMD_NOP && !ack) begin
            state_nxt   = TRK_WAIT;
            cmd_lat_nxt = cmd;
            cnt_nxt     = CNT_ONE;
          end
        end
        TRK_WAIT: begin
          // Ack takes precedence over a simultaneous command change.
          if (ack) begin
            state_nxt = TRK_IDLE;
          end else if (cmd != cmd_lat) begin
            flag_changed = 1'b1;
            state_nxt    = TRK_IDLE;
          end else if (cnt == CNT_MAX) begin
            flag_timeout = 1'b1;
            state_nxt    = TRK_STALLED;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        TRK_STALLED: begin
          // Already reported once; wait quietly for the channel to recover.
          if (ack || cmd == CMD_NOP) state_nxt = TRK_IDLE;
        end
        default: state_nxt = TRK_IDLE;
      endcase
    end
  end

  assign stalled = (state == TRK_STALLED);

endmodule

// File: rtl/mesi_isc_coherence_monitor.sv
// MESI coherence and mbus protocol monitor for the mesi_isc subsystem.
// Every enabled cycle it scans all cpu x line states for illegal encodings,
// multiple owners and (first enabled cycle after reset) non-I lines, and
// collects per-CPU ack tracker flags. Violations are registered one cycle
// later; the first one is captured and a saturating cycle count is kept.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   mon_en        enables all checks
//   err_clr       clears sticky flag, capture registers and counter
//   cache_state   MESI state per line, index (cpu*NUM_LINES+line)*4
//   mbus_cmd      per-CPU mbus command; mbus_ack per-CPU ack
//   err_valid     pulse: a violation occurred in the previous cycle
//   err_sticky    held until err_clr
//   err_code, err_cpu, err_line  first captured violation
//   err_count     violating cycles, saturating
//   ack_timeout   per-CPU, high while that tracker is STALLED
module mesi_isc_coherence_monitor
  import mesi_isc_mon_pkg::*;
#(
  parameter int NUM_CPUS       = 4,
  parameter int NUM_LINES      = 10,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int ACK_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 16,
  localparam int CPU_W  = (NUM_CPUS  > 1) ? $clog2(NUM_CPUS)  : 1,
  localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mon_en,
  input  logic                               err_clr,
  input  logic [NUM_CPUS*NUM_LINES*4-1:0]    cache_state,
  input  logic [NUM_CPUS*MBUS_CMD_WIDTH-1:0] mbus_cmd,
  input  logic [NUM_CPUS-1:0]                mbus_ack,
  output logic                               err_valid,
  output logic                               err_sticky,
  output logic [2:0]                         err_code,
  output logic [CPU_W-1:0]                   err_cpu,
  output logic [LINE_W-1:0]                  err_line,
  output logic [CNT_WIDTH-1:0]               err_count,
  output logic [NUM_CPUS-1:0]                ack_timeout
);

  logic [3:0]          st [NUM_CPUS][NUM_LINES];
  logic [NUM_CPUS-1:0] flag_timeout, flag_changed, stalled;
  trk_state_e          trk_state [NUM_CPUS];
  logic                init_pending;

  logic                viol_any;
  err_code_e           sel_code;
  logic [CPU_W-1:0]    sel_cpu;
  logic [LINE_W-1:0]   sel_line;

  for (genvar c = 0; c < NUM_CPUS; c++) begin : g_cpu
    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
      assign st[c][l] = cache_state[(c*NUM_LINES+l)*4 +: 4];
    end

    mesi_isc_mon_ack_tracker #(
      .MBUS_CMD_WIDTH (MBUS_CMD_WIDTH),
      .ACK_TIMEOUT    (ACK_TIMEOUT)
    ) u_trk (
      .clk          (clk),
      .rst          (rst),
      .en           (mon_en),
      .cmd          (mbus_cmd[c*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH]),
      .ack          (mbus_ack[c]),
      .flag_timeout (flag_timeout[c]),
      .flag_changed (flag_changed[c]),
      .stalled      (stalled[c]),
      .state        (trk_state[c])
    );

    // The debug state and the stalled output must agree; the output port
    // is driven from the state so a stuck 'stalled' wire cannot hide.
    assign ack_timeout[c] = stalled[c] && (trk_state[c] == TRK_STALLED);
  end

  // Priority scan: codes are searched in ascending order, and within a
  // code cpu-major then line, so the first hit is the one to capture.
  always_comb begin
    viol_any = 1'b0;
    sel_code = ERR_NONE;
    sel_cpu  = '0;
    sel_line = '0;
    if (mon_en) begin
      for (int c = 0; c < NUM_CPUS; c++) begin
        for (int l = 0; l < NUM_LINES; l++) begin
          if (!viol_any && !mesi_legal(st[c][l])) begin
            viol_any = 1'b1;
            sel_code = ERR_ILLEGAL_ENC;
            sel_cpu  = CPU_W'(c);
            sel_line = LINE_W'(l);
          end
        end
      end
      // Owner-centric: reported CPU is the M/E holder, not the sharer.
      for (int c = 0; c < NUM_CPUS; c++) begin
        for (int l = 0; l < NUM_LINES; l++) begin
          for (int o = 0; o < NUM_CPUS; o++) begin
            if (!viol_any && o != c && mesi_owner(st[c][l]) &&
                st[o][l] != MESI_I) begin
              viol_any = 1'b1;
              sel_code = ERR_MULTI_OWNER;
              sel_cpu  = CPU_W'(c);
              sel_line = LINE_W'(l);
            end
          end
        end
      end
      if (init_pending) begin
        for (int c = 0; c < NUM_CPUS; c++) begin
          for (int l = 0; l < NUM_LINES; l++) begin
            if (!viol_any && st[c][l] != MESI_I) begin
              viol_any = 1'b1;
              sel_code = ERR_INIT_NOT_I;
              sel_cpu  = CPU_W'(c);
              sel_line = LINE_W'(l);
            end
          end
        end
      end
      for (int c = 0; c < NUM_CPUS; c++) begin
        if (!viol_any && flag_timeout[c]) begin
          viol_any = 1'b1;
          sel_code = ERR_ACK_TIMEOUT;
          sel_cpu  = CPU_W'(c);
        end
      end
      for (int c = 0; c < NUM_CPUS; c++) begin
        if (!viol_any && flag_changed[c]) begin
          viol_any = 1'b1;
          sel_code = ERR_CMD_CHANGED;
          sel_cpu  = CPU_W'(c);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid    <= 1'b0;
      err_sticky   <= 1'b0;
      err_code     <= '0;
      err_cpu      <= '0;
      err_line     <= '0;
      err_count    <= '0;
      init_pending <= 1'b1;
    end else begin
      err_valid <= viol_any;
      if (mon_en) init_pending <= 1'b0;
      if (err_clr) begin
        // A violation in the clearing cycle starts a fresh record.
        err_sticky <= viol_any;
        err_code   <= viol_any ? sel_code : 3'd0;
        err_cpu    <= viol_any ? sel_cpu  : '0;
        err_line   <= viol_any ? sel_line : '0;
        err_count  <= viol_any ? CNT_WIDTH'(1) : '0;
      end else if (viol_any) begin
        if (!err_sticky) begin
          err_code <= sel_code;
          err_cpu  <= sel_cpu;
          err_line <= sel_line;
        end
        err_sticky <= 1'b1;
        if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mesi_isc_coherence_monitor.sv
// Directed bench for mesi_isc_coherence_monitor (4 CPUs, 10 lines,
// ACK_TIMEOUT=16, 4-bit error counter).
module tb_mesi_isc_coherence_monitor;

  localparam logic [3:0] ST_M = 4'b1001;
  localparam logic [3:0] ST_E = 4'b0101;
  localparam logic [3:0] ST_S = 4'b0011;
  localparam logic [3:0] ST_I = 4'b0000;

  logic         clk;
  logic         rst;
  logic         mon_en;
  logic         err_clr;
  logic [159:0] cache_state;
  logic [11:0]  mbus_cmd;
  logic [3:0]   mbus_ack;
  logic         err_valid;
  logic         err_sticky;
  logic [2:0]   err_code;
  logic [1:0]   err_cpu;
  logic [3:0]   err_line;
  logic [3:0]   err_count;
  logic [3:0]   ack_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  mesi_isc_coherence_monitor #(
    .NUM_CPUS       (4),
    .NUM_LINES      (10),
    .MBUS_CMD_WIDTH (3),
    .ACK_TIMEOUT    (16),
    .CNT_WIDTH      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mon_en      (mon_en),
    .err_clr     (err_clr),
    .cache_state (cache_state),
    .mbus_cmd    (mbus_cmd),
    .mbus_ack    (mbus_ack),
    .err_valid   (err_valid),
    .err_sticky  (err_sticky),
    .err_code    (err_code),
    .err_cpu     (err_cpu),
    .err_line    (err_line),
    .err_count   (err_count),
    .ack_timeout (ack_timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int c, input int l, input logic [3:0] v);
    cache_state[(c*10+l)*4 +: 4] = v;
  endtask

  task automatic set_cmd(input int c, input logic [2:0] v);
    mbus_cmd[c*3 +: 3] = v;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  // checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic v, input logic s,
                         input logic [2:0] code, input logic [1:0] cpu,
                         input logic [3:0] line, input logic [3:0] cnt);
    chk({tag, ".valid"},  {31'd0, err_valid},  {31'd0, v});
    chk({tag, ".sticky"}, {31'd0, err_sticky}, {31'd0, s});
    chk({tag, ".code"},   {29'd0, err_code},   {29'd0, code});
    chk({tag, ".cpu"},    {30'd0, err_cpu},    {30'd0, cpu});
    chk({tag, ".line"},   {28'd0, err_line},   {28'd0, line});
    chk({tag, ".count"},  {28'd0, err_count},  {28'd0, cnt});
  endtask

  initial begin
    rst         = 1'b1;
    mon_en      = 1'b0;
    err_clr     = 1'b0;
    cache_state = '0;
    mbus_cmd    = '0;
    mbus_ack    = '0;
    step(2);
    chk_err("reset", 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0);
    chk("reset.ack_timeout", {28'd0, ack_timeout}, 32'd0);

    // quiet system: all I, NOP, monitor on
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("quiet.valid", {31'd0, err_valid}, 32'd0);
    end
    chk("quiet.count", {28'd0, err_count}, 32'd0);

    // init check held off while disabled, then fires on first enabled cycle
    rst = 1'b1;
    step(1);
    rst    = 1'b0;
    mon_en = 1'b0;
    set_line(2, 3, ST_S);
    step(2);
    chk("disabled.valid", {31'd0, err_valid}, 32'd0);
    chk("disabled.sticky", {31'd0, err_sticky}, 32'd0);
    mon_en = 1'b1;
    step(1);
    chk_err("init", 1'b1, 1'b1, 3'd3, 2'd2, 4'd3, 4'd1);
    set_line(2, 3, ST_I);
    step(1);
    chk("init_once.valid", {31'd0, err_valid}, 32'd0);
    chk("init_once.count", {28'd0, err_count}, 32'd1);
    pulse_clr();
    chk_err("clr", 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0);

    // multi-owner for 3 cycles, then clear with a new illegal encoding
    set_line(1, 5, ST_M);
    set_line(3, 5, ST_S);
    step(3);
    chk_err("multi", 1'b1, 1'b1, 3'd2, 2'd1, 4'd5, 4'd3);
    err_clr = 1'b1;
    set_line(0, 0, 4'hF);
    step(1);
    chk_err("clr_new", 1'b1, 1'b1, 3'd1, 2'd0, 4'd0, 4'd1);
    err_clr     = 1'b0;
    cache_state = '0;
    step(1);
    chk_err("after_clr", 1'b0, 1'b1, 3'd1, 2'd0, 4'd0, 4'd1);
    pulse_clr();

    // owner is the higher-numbered CPU; E owner reported, not the sharer
    set_line(0, 9, ST_S);
    set_line(3, 9, ST_E);
    step(1);
    chk_err("owner_hi", 1'b1, 1'b1, 3'd2, 2'd3, 4'd9, 4'd1);
    cache_state = '0;
    step(1);
    pulse_clr();

    // ack timeout on cpu0
    set_cmd(0, 3'd3);
    step(16);
    chk("to16.ack_timeout", {28'd0, ack_timeout}, 32'd0);
    chk("to16.valid", {31'd0, err_valid}, 32'd0);
    step(1);
    chk("to17.ack_timeout", {28'd0, ack_timeout}, 32'd1);
    chk_err("to17", 1'b1, 1'b1, 3'd4, 2'd0, 4'd0, 4'd1);
    step(1);
    chk("stall.valid", {31'd0, err_valid}, 32'd0);
    chk("stall.ack_timeout", {28'd0, ack_timeout}, 32'd1);
    mbus_ack[0] = 1'b1;
    step(1);
    chk("ack.ack_timeout", {28'd0, ack_timeout}, 32'd0);
    chk("ack.valid", {31'd0, err_valid}, 32'd0);
    mbus_ack = '0;
    set_cmd(0, 3'd0);
    step(2);
    chk("post_ack.valid", {31'd0, err_valid}, 32'd0);
    chk("post_ack.count", {28'd0, err_count}, 32'd1);
    pulse_clr();

    // command change while waiting on cpu3
    set_cmd(3, 3'd2);
    step(2);
    set_cmd(3, 3'd1);
    step(1);
    chk_err("changed", 1'b1, 1'b1, 3'd5, 2'd3, 4'd0, 4'd1);
    set_cmd(3, 3'd0);
    step(1);
    chk("changed_nop.valid", {31'd0, err_valid}, 32'd0);
    pulse_clr();

    // single-cycle transaction on cpu2
    set_cmd(2, 3'd2);
    mbus_ack[2] = 1'b1;
    step(1);
    mbus_ack = '0;
    set_cmd(2, 3'd0);
    step(1);
    chk("single.valid", {31'd0, err_valid}, 32'd0);
    chk("single.ack_timeout", {28'd0, ack_timeout}, 32'd0);

    // ack and command change together: ack wins
    set_cmd(1, 3'd4);
    step(1);
    set_cmd(1, 3'd1);
    mbus_ack[1] = 1'b1;
    step(1);
    set_cmd(1, 3'd0);
    mbus_ack = '0;
    step(1);
    chk("ackwins.valid", {31'd0, err_valid}, 32'd0);
    chk("ackwins.sticky", {31'd0, err_sticky}, 32'd0);

    // counter saturation
    set_line(0, 0, 4'hF);
    step(21);
    chk_err("sat", 1'b1, 1'b1, 3'd1, 2'd0, 4'd0, 4'hF);
    cache_state = '0;

    // reset in the middle of a wait; command stays asserted through it
    set_cmd(1, 3'd2);
    step(3);
    rst = 1'b1;
    step(1);
    chk_err("mid_rst", 1'b0, 1'b0, 3'd0, 2'd0, 4'd0, 4'd0);
    chk("mid_rst.ack_timeout", {28'd0, ack_timeout}, 32'd0);
    rst = 1'b0;
    set_line(0, 1, ST_E);
    step(1);
    chk_err("rearm", 1'b1, 1'b1, 3'd3, 2'd0, 4'd1, 4'd1);
    set_line(0, 1, ST_I);
    pulse_clr();
    // tracker restarted at reset: full timeout counted from the first edge after it
    step(14);
    chk("restart16.ack_timeout", {28'd0, ack_timeout}, 32'd0);
    chk("restart16.valid", {31'd0, err_valid}, 32'd0);
    step(1);
    chk("restart17.ack_timeout", {28'd0, ack_timeout}, 32'h2);
    chk_err("restart17", 1'b1, 1'b1, 3'd4, 2'd1, 4'd0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
